// File: rtl/bird_motion_controller_pkg.sv
// Screen geometry, physics defaults and animation codes shared with the
// sprite ROM path.
package bird_motion_controller_pkg;

  typedef enum logic [1:0] {
    ANIM_IDLE = 2'b00,
    ANIM_FLY  = 2'b01,
    ANIM_FALL = 2'b10,
    ANIM_DEAD = 2'b11
  } anim_e;

  localparam logic [10:0] SCR_BIRD_X   = 11'd200;
  localparam logic [10:0] SCR_START_Y  = 11'd240;
  localparam logic [10:0] SCR_TOP_Y    = 11'd16;
  localparam logic [10:0] SCR_GROUND_Y = 11'd464;

  localparam logic signed [7:0] PHY_FLAP_VEL = -8'sd8;
  localparam logic signed [7:0] PHY_GRAVITY  = 8'sd1;
  localparam logic signed [7:0] PHY_MAX_FALL = 8'sd8;

  function automatic logic signed [11:0] sext8(
    input logic signed [7:0] a
  );
    return {{4{a[7]}}, a};
  endfunction

endpackage

// File: rtl/bird_motion_controller_flap_edge_detect.sv
// Rising-edge detector for the synchronised flap button level.
module flap_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/bird_motion_controller.sv
// Bird vertical physics and animation FSM, updated once per video frame.
module bird_motion_controller
  import bird_motion_controller_pkg::*;
#(
  parameter logic [10:0]       BIRD_X   = SCR_BIRD_X,
  parameter logic [10:0]       START_Y  = SCR_START_Y,
  parameter logic [10:0]       TOP_Y    = SCR_TOP_Y,
  parameter logic [10:0]       GROUND_Y = SCR_GROUND_Y,
  parameter logic signed [7:0] FLAP_VEL = PHY_FLAP_VEL,
  parameter logic signed [7:0] GRAVITY  = PHY_GRAVITY,
  parameter logic signed [7:0] MAX_FALL = PHY_MAX_FALL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        flap,
  input  logic        collide,
  input  logic        start,
  output logic [10:0] bird_h,
  output logic [10:0] bird_v,
  output logic [1:0]  anim_state,
  output logic        game_over
);

  localparam logic signed [11:0] LP_TOP  = {1'b0, TOP_Y};
  localparam logic signed [11:0] LP_GND  = {1'b0, GROUND_Y};
  localparam logic signed [11:0] LP_MAXF = {{4{MAX_FALL[7]}}, MAX_FALL};

  anim_e             r_state;
  anim_e             w_state_nxt;
  logic [10:0]       r_bird_v;
  logic [10:0]       w_v_nxt;
  logic signed [7:0] r_vel;
  logic signed [7:0] w_vel_nxt;
  logic              r_flap_pend;
  logic              w_pend_nxt;
  logic              r_game_over;
  logic              w_go_nxt;

  logic              w_rise;
  logic              w_pend;
  logic              w_fly_tick;
  logic              w_in_air;
  logic              w_hit_top;
  logic              w_hit_gnd;
  logic signed [11:0] w_v_cur;
  logic signed [11:0] w_vel_base;
  logic signed [11:0] w_v_sum;
  logic signed [11:0] w_vel_inc;
  logic signed [11:0] w_vel_sat;
  logic signed [11:0] w_v_dead;
  logic              w_unused;

  flap_edge_detect u_flap_edge (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_level (flap),
    .o_rise  (w_rise)
  );

  // A rise in the tick cycle itself joins the frame's update.
  assign w_pend   = r_flap_pend | w_rise;
  assign w_in_air = (r_state == ANIM_FLY) || (r_state == ANIM_FALL);

  // Leaving IDLE, the flap velocity is used as this frame's velocity.
  assign w_v_cur    = {1'b0, r_bird_v};
  assign w_vel_base = (r_state == ANIM_IDLE) ? sext8(FLAP_VEL)
                                             : sext8(r_vel);
  assign w_v_sum    = w_v_cur + w_vel_base;
  assign w_vel_inc  = w_vel_base + sext8(GRAVITY);
  assign w_vel_sat  = (w_vel_inc > LP_MAXF) ? LP_MAXF : w_vel_inc;
  assign w_hit_top  = w_v_sum < LP_TOP;
  assign w_hit_gnd  = w_v_sum >= LP_GND;
  assign w_v_dead   = w_v_cur + LP_MAXF;

  assign w_unused = ^{w_v_sum[11], w_vel_sat[11:8], w_v_dead[11]};

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_bird_v;
    w_vel_nxt   = r_vel;
    w_pend_nxt  = frame_tick ? 1'b0 : w_pend;
    w_fly_tick  = 1'b0;

    unique case (r_state)
      ANIM_IDLE: begin
        w_v_nxt    = START_Y;
        w_vel_nxt  = '0;
        w_fly_tick = frame_tick & w_pend;
      end
      ANIM_FLY, ANIM_FALL: begin
        w_fly_tick = frame_tick;
      end
      ANIM_DEAD: begin
        if (start && r_game_over) begin
          w_state_nxt = ANIM_IDLE;
          w_v_nxt     = START_Y;
          w_vel_nxt   = '0;
        end else if (frame_tick) begin
          w_v_nxt = (w_v_dead >= LP_GND) ? GROUND_Y
                                         : w_v_dead[10:0];
        end
      end
      default: ;
    endcase

    if (w_fly_tick) begin
      if (w_hit_gnd) begin
        w_state_nxt = ANIM_DEAD;
        w_v_nxt     = GROUND_Y;
        w_vel_nxt   = MAX_FALL;
      end else if (w_hit_top) begin
        w_v_nxt   = TOP_Y;
        w_vel_nxt = '0;
      end else begin
        w_v_nxt   = w_v_sum[10:0];
        w_vel_nxt = (w_pend && w_in_air) ? FLAP_VEL
                                         : w_vel_sat[7:0];
      end
      if (!w_hit_gnd) begin
        if (w_pend)              w_state_nxt = ANIM_FLY;
        else if (!w_vel_nxt[7])  w_state_nxt = ANIM_FALL;
      end
    end

    // A pipe hit kills the bird on this edge, tick or not.
    if (collide && w_in_air) begin
      w_state_nxt = ANIM_DEAD;
      w_vel_nxt   = MAX_FALL;
    end

    if (w_state_nxt == ANIM_DEAD) w_pend_nxt = 1'b0;

    w_go_nxt = (w_state_nxt == ANIM_DEAD) && (w_v_nxt == GROUND_Y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ANIM_IDLE;
      r_bird_v    <= START_Y;
      r_vel       <= '0;
      r_flap_pend <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bird_v    <= w_v_nxt;
      r_vel       <= w_vel_nxt;
      r_flap_pend <= w_pend_nxt;
      r_game_over <= w_go_nxt;
    end
  end

  assign bird_h     = BIRD_X;
  assign bird_v     = r_bird_v;
  assign anim_state = r_state;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_bird_motion_controller.sv
// Directed plus randomised bench for bird_motion_controller against a
// frame-level behavioural model.
module tb_bird_motion_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        flap;
  logic        collide;
  logic        start;
  logic [10:0] bird_h;
  logic [10:0] bird_v;
  logic [1:0]  anim_state;
  logic        game_over;

  int n_tests = 0;
  int n_fail  = 0;

  // model: st 0 idle, 1 fly, 2 fall, 3 dead
  int m_st, m_v, m_vel;
  bit m_pend, m_prev, m_go;

  bird_motion_controller dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .flap       (flap),
    .collide    (collide),
    .start      (start),
    .bird_h     (bird_h),
    .bird_v     (bird_v),
    .anim_state (anim_state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_st = 0; m_v = 240; m_vel = 0;
    m_pend = 0; m_prev = 0; m_go = 0;
  endfunction

  // Frame physics: position moves by the current velocity, then gravity.
  function automatic void model_fly(int nv, int nvel, bit pend);
    if (nv >= 464) begin
      m_v = 464; m_st = 3; m_vel = 8;
    end else begin
      if (nv < 16) begin
        m_v = 16; m_vel = 0;
      end else begin
        m_v = nv; m_vel = nvel;
      end
      if (pend) m_st = 1;
      else if (m_vel >= 0) m_st = 2;
    end
  endfunction

  function automatic void model_step(bit t, bit f, bit c, bit s);
    bit pend;
    int gv;
    pend = m_pend || (f && !m_prev);
    m_prev = f;
    if (m_st == 3) begin
      pend = 0;
      if (s && m_go) begin
        m_st = 0; m_v = 240; m_vel = 0;
      end else if (t) begin
        m_v = (m_v + 8 > 464) ? 464 : m_v + 8;
      end
    end else if (m_st == 0) begin
      m_v = 240; m_vel = 0;
      if (t && pend) model_fly(240 - 8, -7, 1'b1);
    end else begin
      if (t) begin
        gv = (m_vel + 1 > 8) ? 8 : m_vel + 1;
        model_fly(m_v + m_vel, pend ? -8 : gv, pend);
      end
      if (c) begin
        m_st = 3; m_vel = 8;
      end
    end
    m_pend = (t || m_st == 3) ? 1'b0 : pend;
    m_go = (m_st == 3) && (m_v == 464);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".v"}, 32'(bird_v), m_v);
    chk({tag, ".anim"}, 32'(anim_state), m_st);
    chk({tag, ".go"}, 32'(game_over), 32'(m_go));
    chk({tag, ".h"}, 32'(bird_h), 200);
  endtask

  task automatic step(input bit t, input bit f, input bit c,
                      input bit s);
    @(negedge clk);
    frame_tick = t; flap = f; collide = c; start = s;
    @(posedge clk);
    model_step(t, f, c, s);
    #1;
  endtask

  initial begin
    int v_hold;
    int min_v;
    rst = 1'b1;
    frame_tick = 0; flap = 0; collide = 0; start = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.anim", 32'(anim_state), 0);
    chk("rst.v", 32'(bird_v), 240);
    chk("rst.go", 32'(game_over), 0);
    chk("rst.h", 32'(bird_h), 200);
    @(negedge clk);
    rst = 1'b0;

    // idle ticks without a flap hold the start position
    step(1, 0, 0, 0);
    chk_model("idle");

    // flap pulse then one tick
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("first.anim", 32'(anim_state), 1);
    chk("first.v", 32'(bird_v), 232);
    chk_model("first");

    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0);
      chk_model("climb");
      step(0, 0, 0, 0);
    end
    chk("apex.anim", 32'(anim_state), 2);
    chk("apex.v", 32'(bird_v), 204);

    for (int i = 0; i < 60 && bird_v < 290; i++) begin
      step(1, 0, 0, 0);
      chk_model("drop");
    end
    chk("drop.anim", 32'(anim_state), 2);

    // pipe hit without a tick
    v_hold = int'(bird_v);
    step(0, 0, 1, 0);
    chk("hit.anim", 32'(anim_state), 3);
    chk("hit.v", 32'(bird_v), v_hold);
    chk_model("hit");

    step(0, 0, 0, 1);
    chk("early_start.anim", 32'(anim_state), 3);
    chk("early_start.v", 32'(bird_v), v_hold);

    for (int i = 0; i < 40 && !game_over; i++) begin
      step(1, i[0], 0, 0);
      chk_model("dead_fall");
    end
    chk("land.v", 32'(bird_v), 464);
    chk("land.go", 32'(game_over), 1);
    chk("land.anim", 32'(anim_state), 3);

    step(0, 0, 0, 1);
    chk("restart.anim", 32'(anim_state), 0);
    chk("restart.v", 32'(bird_v), 240);
    chk("restart.go", 32'(game_over), 0);

    // flap edge on every tick drives the bird into the ceiling
    min_v = 2047;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0);
      chk_model("ceil");
      n_tests++;
      assert (bird_v >= 11'd16) else begin
        n_fail++;
        $error("FAIL ceil.floor got=%0d exp>=16", bird_v);
      end
      if (int'(bird_v) < min_v) min_v = int'(bird_v);
      step(0, 0, 0, 0);
    end
    chk("ceil.min", 32'(min_v), 16);

    // pending flap, then asynchronous reset mid-cycle
    step(0, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async.anim", 32'(anim_state), 0);
    chk("async.v", 32'(bird_v), 240);
    chk("async.go", 32'(game_over), 0);
    @(negedge clk);
    rst = 1'b0;
    flap = 0; frame_tick = 0; collide = 0; start = 0;
    step(1, 0, 0, 0);
    chk("nopend.anim", 32'(anim_state), 0);
    chk_model("nopend");

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
      chk_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
